// File: rtl/game_event_controller_if.sv
// Pixel/event bundle between the video pipeline and the game controller.
// The master drives draw requests and frame timing; the slave reports game events.
interface game_event_controller_if #(
    parameter int TILE_W = 2
);
    logic              startOfFrame;
    logic              drawing_request_Ball;
    logic              drawing_request_Tile;
    logic              drawing_request_Border;
    logic [TILE_W-1:0] TileType;
    logic [3:0]        HitEdgeCode;
    logic              startGame;
    logic              collision;
    logic              jumpCollision;
    logic              SingleHitPulse;
    logic              GiftPulse;
    logic              RespawnPulse;
    logic [7:0]        giftsLeft;
    logic [3:0]        livesLeft;
    logic              showHole;
    logic              victory;
    logic              Loss;
    logic              EndGame;
    logic [1:0]        gameState;

    modport master (
        output startOfFrame, drawing_request_Ball, drawing_request_Tile,
        output drawing_request_Border, TileType, HitEdgeCode, startGame,
        input  collision, jumpCollision, SingleHitPulse, GiftPulse,
        input  RespawnPulse, giftsLeft, livesLeft, showHole,
        input  victory, Loss, EndGame, gameState
    );

    modport slave (
        input  startOfFrame, drawing_request_Ball, drawing_request_Tile,
        input  drawing_request_Border, TileType, HitEdgeCode, startGame,
        output collision, jumpCollision, SingleHitPulse, GiftPulse,
        output RespawnPulse, giftsLeft, livesLeft, showHole,
        output victory, Loss, EndGame, gameState
    );
endinterface

// File: rtl/game_event_controller.sv
// Game event controller: per-frame collision/gift/hole/loss detection,
// gift and life bookkeeping, and the IDLE/PLAY/WIN/LOSE game FSM.
module game_event_controller #(
    parameter int                TILE_W        = 2,
    parameter logic [TILE_W-1:0] TT_BACKGROUND = TILE_W'(0),
    parameter logic [TILE_W-1:0] TT_FLOOR      = TILE_W'(1),
    parameter logic [TILE_W-1:0] TT_GIFT       = TILE_W'(2),
    parameter logic [TILE_W-1:0] TT_HOLE       = TILE_W'(3),
    parameter int                NUM_GIFTS     = 4,
    parameter int                NUM_LIVES     = 3,
    parameter logic [3:0]        LOSS_EDGE     = 4'b0001
) (
    input  logic clk,
    input  logic reset,
    game_event_controller_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_WIN  = 2'd2,
        S_LOSE = 2'd3
    } state_t;

    localparam logic [7:0] GIFTS_INIT = 8'(NUM_GIFTS);
    localparam logic [3:0] LIVES_INIT = 4'(NUM_LIVES);

    state_t     state_q, state_d;
    logic [7:0] gifts_q, gifts_d;
    logic [3:0] lives_q, lives_d;
    logic       hit_q, hit_d, gift_q, gift_d;
    logic       hole_q, hole_d, loss_q, loss_d;
    logic       hit_pulse_q, hit_pulse_d;
    logic       gift_pulse_q, gift_pulse_d;
    logic       respawn_q, respawn_d;

    logic ball, tile, border, show_hole;
    logic coll, gift_ov, hole_ov, loss_ov;
    logic hit_f, gift_f, hole_f, loss_f;

    assign ball      = bus.drawing_request_Ball;
    assign tile      = bus.drawing_request_Tile;
    assign border    = bus.drawing_request_Border;
    assign show_hole = (gifts_q == 8'd0);

    assign coll    = ball & ((tile & (bus.TileType == TT_FLOOR)) | border);
    assign gift_ov = ball & tile & (bus.TileType == TT_GIFT);
    assign hole_ov = ball & tile & (bus.TileType == TT_HOLE);
    assign loss_ov = ball & border & (bus.HitEdgeCode == LOSS_EDGE);

    // Frame flags as seen this cycle: the start-of-frame clear wins first
    assign hit_f  = hit_q  & ~bus.startOfFrame;
    assign gift_f = gift_q & ~bus.startOfFrame;
    assign hole_f = hole_q & ~bus.startOfFrame;
    assign loss_f = loss_q & ~bus.startOfFrame;

    // Next-state, counter and pulse logic for the game FSM
    always_comb begin
        state_d      = state_q;
        gifts_d      = gifts_q;
        lives_d      = lives_q;
        hit_d        = hit_f;
        gift_d       = gift_f;
        hole_d       = hole_f;
        loss_d       = loss_f;
        hit_pulse_d  = 1'b0;
        gift_pulse_d = 1'b0;
        respawn_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.startGame) begin
                    state_d = S_PLAY;
                    gifts_d = GIFTS_INIT;
                    lives_d = LIVES_INIT;
                    hit_d   = 1'b0;
                    gift_d  = 1'b0;
                    hole_d  = 1'b0;
                    loss_d  = 1'b0;
                end
            end
            S_PLAY: begin
                if (coll && !hit_f) begin
                    hit_d       = 1'b1;
                    hit_pulse_d = 1'b1;
                end
                if (gift_ov && !gift_f) begin
                    gift_d = 1'b1;
                    if (gifts_q != 8'd0) begin
                        gifts_d      = gifts_q - 8'd1;
                        gift_pulse_d = 1'b1;
                    end
                end
                if (loss_ov && !loss_f) begin
                    loss_d = 1'b1;
                    if (lives_q > 4'd1) begin
                        lives_d   = lives_q - 4'd1;
                        respawn_d = 1'b1;
                    end else begin
                        lives_d = 4'd0;
                        state_d = S_LOSE;
                    end
                end
                // A hole win overrides a simultaneous final loss
                if (hole_ov && show_hole && !hole_f) begin
                    hole_d  = 1'b1;
                    state_d = S_WIN;
                end
            end
            S_WIN, S_LOSE: begin
                if (bus.startGame) state_d = S_IDLE;
            end
        endcase
    end

    // State, counter, flag and pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            gifts_q      <= GIFTS_INIT;
            lives_q      <= LIVES_INIT;
            hit_q        <= 1'b0;
            gift_q       <= 1'b0;
            hole_q       <= 1'b0;
            loss_q       <= 1'b0;
            hit_pulse_q  <= 1'b0;
            gift_pulse_q <= 1'b0;
            respawn_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            gifts_q      <= gifts_d;
            lives_q      <= lives_d;
            hit_q        <= hit_d;
            gift_q       <= gift_d;
            hole_q       <= hole_d;
            loss_q       <= loss_d;
            hit_pulse_q  <= hit_pulse_d;
            gift_pulse_q <= gift_pulse_d;
            respawn_q    <= respawn_d;
        end
    end

    assign bus.collision      = coll;
    assign bus.jumpCollision  = ball & tile & (bus.TileType == TT_BACKGROUND);
    assign bus.SingleHitPulse = hit_pulse_q;
    assign bus.GiftPulse      = gift_pulse_q;
    assign bus.RespawnPulse   = respawn_q;
    assign bus.giftsLeft      = gifts_q;
    assign bus.livesLeft      = lives_q;
    assign bus.showHole       = show_hole;
    assign bus.victory        = (state_q == S_WIN);
    assign bus.Loss           = (state_q == S_LOSE);
    assign bus.EndGame        = (state_q == S_WIN) | (state_q == S_LOSE);
    assign bus.gameState      = state_q;
endmodule

// File: tb/tb_game_event_controller.sv
// Directed scoreboard bench for game_event_controller.
// Expectations are queued with the stimulus and drained after each edge.
module tb_game_event_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;

    game_event_controller_if #(.TILE_W(2)) ifc ();

    game_event_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   hit_cnt = 0;

    always @(negedge clk) if (ifc.SingleHitPulse === 1'b1) hit_cnt++;

    function automatic logic [31:0] actual(string tag);
        case (tag)
            "state":   return 32'(ifc.gameState);
            "gifts":   return 32'(ifc.giftsLeft);
            "lives":   return 32'(ifc.livesLeft);
            "hit":     return 32'(ifc.SingleHitPulse);
            "gift":    return 32'(ifc.GiftPulse);
            "respawn": return 32'(ifc.RespawnPulse);
            "hole":    return 32'(ifc.showHole);
            "victory": return 32'(ifc.victory);
            "loss":    return 32'(ifc.Loss);
            "end":     return 32'(ifc.EndGame);
            "coll":    return 32'(ifc.collision);
            "jump":    return 32'(ifc.jumpCollision);
            "hitcnt":  return 32'(hit_cnt);
            default:   return 32'hdead_beef;
        endcase
    endfunction

    task automatic want(string tag, int v);
        exp_t e;
        e.tag = tag;
        e.exp = 32'(v);
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            act = actual(e.tag);
            checks++;
            assert (act === e.exp) passes++;
            else $error("FAIL %s: got %0d expected %0d", e.tag, act, e.exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ov(logic b, logic t, logic [1:0] tt, logic bd, logic [3:0] ec);
        ifc.drawing_request_Ball   = b;
        ifc.drawing_request_Tile   = t;
        ifc.TileType               = tt;
        ifc.drawing_request_Border = bd;
        ifc.HitEdgeCode            = ec;
    endtask

    task automatic frame();
        ov(0, 0, 0, 0, 0);
        ifc.startOfFrame = 1'b1;
        cyc(1);
        ifc.startOfFrame = 1'b0;
    endtask

    task automatic start();
        ifc.startGame = 1'b1;
        cyc(1);
        ifc.startGame = 1'b0;
    endtask

    task automatic gift_step(int g, int p);
        frame();
        ov(1, 1, 2'd2, 0, 0);
        cyc(1);
        want("gift", p);
        want("gifts", g);
        want("hole", (g == 0) ? 1 : 0);
        drain();
        ov(0, 0, 0, 0, 0);
        cyc(1);
        want("gift", 0);
        drain();
    endtask

    task automatic loss_step(int l, int r, int s);
        frame();
        ov(1, 0, 0, 1, 4'b0001);
        cyc(1);
        want("lives", l);
        want("respawn", r);
        want("state", s);
        drain();
        ov(0, 0, 0, 0, 0);
        cyc(1);
        want("respawn", 0);
        drain();
    endtask

    initial begin
        ifc.startOfFrame = 1'b0;
        ifc.startGame    = 1'b0;
        ov(0, 0, 0, 0, 0);
        cyc(2);
        reset = 1'b0;
        want("state", 0); want("gifts", 4); want("lives", 3);
        want("hit", 0); want("gift", 0); want("respawn", 0);
        want("hole", 0); want("victory", 0); want("loss", 0); want("end", 0);
        drain();

        ov(1, 1, 2'd1, 0, 0); #1;
        want("coll", 1); want("jump", 0); drain();
        ov(1, 1, 2'd0, 0, 0); #1;
        want("coll", 0); want("jump", 1); drain();
        ov(1, 0, 2'd0, 1, 0); #1;
        want("coll", 1); want("jump", 0); drain();
        ov(0, 1, 2'd1, 1, 0); #1;
        want("coll", 0); want("jump", 0); drain();
        ov(0, 0, 0, 0, 0);

        start();
        want("state", 1); want("gifts", 4); want("lives", 3); drain();

        frame();
        hit_cnt = 0;
        ov(1, 1, 2'd1, 0, 0);
        cyc(50);
        want("hitcnt", 1); drain();
        ifc.startOfFrame = 1'b1;
        cyc(1);
        want("hit", 1); drain();
        ifc.startOfFrame = 1'b0;
        cyc(1);
        want("hit", 0); drain();
        cyc(10);
        ov(0, 0, 0, 0, 0);
        cyc(2);
        want("hitcnt", 2); drain();

        gift_step(3, 1);
        gift_step(2, 1);
        frame();
        ov(1, 1, 2'd3, 0, 0);
        cyc(1);
        want("state", 1); want("victory", 0); drain();
        ov(0, 0, 0, 0, 0);
        start();
        want("state", 1); want("gifts", 2); drain();
        gift_step(1, 1);
        gift_step(0, 1);
        gift_step(0, 0);
        frame();
        ov(1, 1, 2'd3, 0, 0);
        cyc(1);
        want("state", 2); want("victory", 1); want("end", 1); want("loss", 0);
        drain();
        ov(0, 0, 0, 0, 0);

        start();
        want("state", 0); want("victory", 0); want("end", 0); drain();
        start();
        want("state", 1); want("gifts", 4); want("lives", 3); drain();
        frame();
        ov(1, 0, 0, 1, 4'b0010);
        cyc(1);
        want("lives", 3); want("respawn", 0); drain();
        loss_step(2, 1, 1);
        loss_step(1, 1, 1);
        loss_step(0, 0, 3);
        want("loss", 1); want("end", 1); want("victory", 0); drain();

        start();
        want("state", 0); drain();
        start();
        want("state", 1); want("lives", 3); drain();
        gift_step(3, 1);
        gift_step(2, 1);
        gift_step(1, 1);
        gift_step(0, 1);
        loss_step(2, 1, 1);
        loss_step(1, 1, 1);
        frame();
        ov(1, 1, 2'd3, 1, 4'b0001);
        cyc(1);
        want("state", 2); want("victory", 1); want("loss", 0); drain();
        ov(0, 0, 0, 0, 0);

        start();
        start();
        want("state", 1); drain();
        gift_step(3, 1);
        loss_step(2, 1, 1);
        frame();
        reset = 1'b1;
        ov(1, 1, 2'd2, 0, 0);
        cyc(1);
        want("state", 0); want("gifts", 4); want("lives", 3);
        want("gift", 0); want("hole", 0);
        drain();
        reset = 1'b0;
        ov(0, 0, 0, 0, 0);
        cyc(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
